// File: rtl/rom_byte_streamer_pkg.sv
// Shared types and constants for the ROM byte streamer.
package rom_byte_streamer_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        LOAD,
        EMIT
    } state_e;

endpackage

// File: rtl/rom_byte_streamer_if.sv
// Control, ROM and byte-stream signals of the ROM byte streamer.
// master: the streamer itself; slave: the ROM plus the stream consumer.
interface rom_byte_streamer_if
    import rom_byte_streamer_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = ADDR_WIDTH + $clog2(DATA_WIDTH / BYTE_W) + 1
);
    logic                  start;
    logic [LEN_WIDTH-1:0]  length;
    logic                  rom_rd_en;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [BYTE_W-1:0]     out_data;
    logic                  out_last;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, length, rom_data, out_ready,
        output rom_rd_en, rom_addr, out_valid, out_data, out_last, busy, done
    );

    modport slave (
        output start, length, rom_data, out_ready,
        input  rom_rd_en, rom_addr, out_valid, out_data, out_last, busy, done
    );

endinterface

// File: rtl/rom_word_unpacker.sv
// Holds one ROM word and presents its bytes little-endian, one per advance.
module rom_word_unpacker
    import rom_byte_streamer_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  adv_i,
    output logic [BYTE_W-1:0]     byte_o,
    output logic                  first_o,
    output logic                  last_o
);
    localparam int WORD_BYTES = DATA_WIDTH / BYTE_W;
    localparam int IDX_W      = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_BYTES - 1);

    logic [WORD_BYTES-1:0][BYTE_W-1:0] word_q;
    logic [IDX_W-1:0]                  idx_q;

    // Load restarts at byte 0; advance walks toward the MSB byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (load_i) begin
            word_q <= data_i;
            idx_q  <= '0;
        end else if (adv_i) begin
            idx_q  <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    assign byte_o  = word_q[idx_q];
    assign first_o = (idx_q == '0);
    assign last_o  = (idx_q == IDX_LAST);

endmodule

// File: rtl/rom_byte_streamer.sv
// Streams the first `length` bytes of an external registered-read ROM,
// little-endian within each word, over a valid/ready byte interface.
// Optional macro ROM_BYTE_STREAMER_PREFETCH_EN: fetch the next word while the
// current one drains so word boundaries cost no bubble cycles.
module rom_byte_streamer
    import rom_byte_streamer_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = ADDR_WIDTH + $clog2(DATA_WIDTH / BYTE_W) + 1
) (
    input logic                 clk,
    input logic                 rst,
    rom_byte_streamer_if.master bus
);
`ifdef ROM_BYTE_STREAMER_PREFETCH_EN
    localparam bit PREFETCH_EN = 1'b1;
`else
    localparam bit PREFETCH_EN = 1'b0;
`endif

    localparam int WORD_BYTES = DATA_WIDTH / BYTE_W;
    // Clamp limit: the whole ROM, so the word address can never wrap.
    localparam logic [LEN_WIDTH-1:0] CAP  = LEN_WIDTH'((2 ** ADDR_WIDTH) * WORD_BYTES);
    localparam logic [LEN_WIDTH-1:0] WB_L = LEN_WIDTH'(WORD_BYTES);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic                  done_q, done_d;
    logic                  pf_sent_q, pf_sent_d;
    logic                  rd_inflight_q;
    logic [DATA_WIDTH-1:0] pend_q;
    logic                  pend_vld_q;

    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  ld;
    logic                  adv;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  idx_first;
    logic                  word_last;

    // Pending word (prefetch only) takes priority over the live ROM bus.
    assign ld_data = pend_vld_q ? pend_q : bus.rom_data;

    rom_word_unpacker #(.DATA_WIDTH(DATA_WIDTH)) u_unpack (
        .clk    (clk),
        .rst    (rst),
        .load_i (ld),
        .data_i (ld_data),
        .adv_i  (adv),
        .byte_o (bus.out_data),
        .first_o(idx_first),
        .last_o (word_last)
    );

    // State, address, remaining-byte count and done pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            done_q    <= 1'b0;
            pf_sent_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            done_q    <= done_d;
            pf_sent_q <= pf_sent_d;
        end
    end

    // Track reads in flight and park a prefetched word until the current one drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_inflight_q <= 1'b0;
            pend_q        <= '0;
            pend_vld_q    <= 1'b0;
        end else begin
            rd_inflight_q <= rd_en;
            if (ld) begin
                pend_vld_q <= 1'b0;
            end else if (PREFETCH_EN && rd_inflight_q && state_q == EMIT) begin
                pend_q     <= bus.rom_data;
                pend_vld_q <= 1'b1;
            end
        end
    end

    // Next-state, ROM read, word load and byte advance decisions.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        done_d    = 1'b0;
        pf_sent_d = pf_sent_q;
        rd_en     = 1'b0;
        rd_addr   = addr_q;
        ld        = 1'b0;
        adv       = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        rem_d   = (bus.length > CAP) ? CAP : bus.length;
                        addr_d  = '0;
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                rd_en   = 1'b1;
                state_d = LOAD;
            end
            LOAD: begin
                ld        = 1'b1;
                pf_sent_d = 1'b0;
                state_d   = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                // First cycle of a word with another word behind it: fetch ahead.
                if (PREFETCH_EN && idx_first && !pf_sent_q && rem_q > WB_L) begin
                    rd_en     = 1'b1;
                    rd_addr   = addr_q + 1'b1;
                    addr_d    = addr_q + 1'b1;
                    pf_sent_d = 1'b1;
                end
                if (bus.out_ready) begin
                    adv   = 1'b1;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (word_last) begin
                        if (PREFETCH_EN) begin
                            // Data parked or arriving now: swap in without a bubble.
                            // Otherwise the read went out this cycle; LOAD catches it.
                            if (pend_vld_q || rd_inflight_q) begin
                                ld        = 1'b1;
                                pf_sent_d = 1'b0;
                            end else begin
                                state_d = LOAD;
                            end
                        end else begin
                            addr_d  = addr_q + 1'b1;
                            state_d = FETCH;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rom_rd_en = rd_en;
    assign bus.rom_addr  = rd_addr;
    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_valid && (rem_q == LEN_WIDTH'(1));
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;

endmodule

// File: tb/tb_rom_byte_streamer.sv
// Bench for rom_byte_streamer: registered-read ROM model, byte-array
// reference, directed cases followed by randomized lengths and back-pressure.
module tb_rom_byte_streamer;
    import rom_byte_streamer_pkg::*;

    localparam int AW    = 3;
    localparam int DW    = 32;
    localparam int WB    = DW / 8;
    localparam int LW    = AW + $clog2(WB) + 1;
    localparam int WORDS = 1 << AW;
    localparam int CAPB  = WORDS * WB;
`ifdef ROM_BYTE_STREAMER_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rom_byte_streamer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    rom_byte_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [DW-1:0] rom [WORDS];

    // Registered-read ROM: data appears the cycle after the read enable.
    always @(posedge clk) begin
        if (bus.rom_rd_en) bus.rom_data <= rom[bus.rom_addr];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the ROM viewed as one flat little-endian byte array.
    function automatic logic [7:0] exp_byte(input int i);
        logic [DW-1:0] w;
        w = rom[i / WB];
        return w[8 * (i % WB) +: 8];
    endfunction

    // mode 0: always ready; 1: random ready plus stray starts; 2: ready 1,0,0,1 over valid cycles.
    // abort_at > 0 returns once that many bytes are committed to transfer.
    task automatic run_stream(input int len, input int mode, input int abort_at, input string tag);
        int n, words, got, rds, exp_addr, first_v, done_c, done_n, last_c;
        int gaps, hold_bad, addr_bad, lastlow_bad, k;
        logic [7:0] held;
        logic held_last;
        bit stalled;
        n = (len > CAPB) ? CAPB : len;
        words = (n + WB - 1) / WB;
        got = 0; rds = 0; exp_addr = 0; first_v = -1; done_c = -1; done_n = 0; last_c = -1;
        gaps = 0; hold_bad = 0; addr_bad = 0; lastlow_bad = 0; k = 0; stalled = 0;
        held = '0; held_last = 1'b0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.length = LW'(len);
        bus.out_ready = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.rom_rd_en) begin
                if (bus.rom_addr !== AW'(exp_addr)) addr_bad++;
                exp_addr++;
                rds++;
            end
            if (bus.out_valid) begin
                if (mode == 1) bus.out_ready = 1'($urandom % 2);
                else if (mode == 2) bus.out_ready = (k % 4 == 0) || (k % 4 == 3);
                else bus.out_ready = 1'b1;
                k++;
                if (first_v < 0) first_v = c;
                if (stalled && (bus.out_data !== held || bus.out_last !== held_last)) hold_bad++;
                if (bus.out_ready) begin
                    chk({tag, "_byte"}, 32'(bus.out_data), 32'(exp_byte(got)));
                    chk({tag, "_last"}, 32'(bus.out_last), 32'(got == n - 1));
                    got++;
                    if (got == n) last_c = c;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held = bus.out_data;
                    held_last = bus.out_last;
                end
            end else begin
                bus.out_ready = 1'b1;
                if (bus.out_last) lastlow_bad++;
                if (got > 0 && got < n) gaps++;
            end
            if (bus.done) begin
                done_n++;
                if (done_c < 0) done_c = c;
            end
            if (mode == 1 && got > 0 && got < n) begin
                bus.start  = 1'($urandom % 2);
                bus.length = LW'($urandom);
            end
            if (abort_at > 0 && got == abort_at) return;
            if (done_c > 0 && c > done_c) break;
        end
        bus.start = 1'b0;
        chk({tag, "_count"}, got, n);
        chk({tag, "_done_cyc"}, done_c, (n == 0) ? 1 : last_c + 1);
        chk({tag, "_done_once"}, done_n, 1);
        chk({tag, "_reads"}, rds, words);
        chk({tag, "_addr"}, addr_bad, 0);
        chk({tag, "_hold"}, hold_bad, 0);
        chk({tag, "_last_lo"}, lastlow_bad, 0);
        chk({tag, "_busy_end"}, 32'(bus.busy), 0);
        if (n > 0) begin
            chk({tag, "_latency"}, first_v, 3);
            chk({tag, "_gaps"}, gaps, PF ? 0 : 2 * (words - 1));
        end else begin
            chk({tag, "_no_valid"}, first_v, -1);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rd_en"}, 32'(bus.rom_rd_en), 0);
        chk({tag, "_addr0"}, 32'(bus.rom_addr), 0);
        chk({tag, "_valid"}, 32'(bus.out_valid), 0);
        chk({tag, "_data"}, 32'(bus.out_data), 0);
        chk({tag, "_last0"}, 32'(bus.out_last), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_done0"}, 32'(bus.done), 0);
    endtask

    initial begin
        rom[0] = 32'h0302_0100;
        rom[1] = 32'h0706_0504;
        for (int i = 2; i < WORDS; i++) rom[i] = $urandom;
        bus.start     = 1'b0;
        bus.length    = '0;
        bus.out_ready = 1'b0;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b0;

        run_stream(8, 0, 0, "len8");
        run_stream(6, 0, 0, "len6");
        run_stream(0, 0, 0, "len0");
        run_stream(8, 2, 0, "stall");

        // Reset in the middle of a stream, then a clean short stream.
        run_stream(8, 0, 3, "abort");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_outputs_zero("midrst");
        rst = 1'b0;
        run_stream(4, 0, 0, "after_rst");

        run_stream(40, 0, 0, "len40");
        run_stream(CAPB, 2, 0, "full_stall");

        for (int r = 0; r < 6; r++) begin
            run_stream(int'($urandom_range(1, 45)), 1, 0, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
